fft_input_loader: RTL and testbench

// - Consumer of the sampler's sample/imag/run/addr strobes. Captures an N-point complex frame from the ADC into the FFT working RAM.
// - On a sample strobe, latches din as the real part (imag=0) or the imaginary part (imag=1) of point addr.
// - On the imaginary strobe, issues one RAM write of the {re,im} pair, optionally at the bit-reversed address.
// - Presents the completed frame to the FFT controller with a valid/ack handshake.

---
 rtl/fft_input_loader_if.sv | 34 +++
 rtl/fft_input_loader.sv | 151 +++++++++++++++
 tb/tb_fft_input_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_loader_if.sv
// Sampler-to-loader bus: capture strobes in, RAM write port and frame handshake out.
// master = sampler/FFT-controller side, slave = fft_input_loader.
interface fft_input_loader_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 16
);
  localparam int unsigned AW = $clog2(N);

  logic          sample;
  logic          imag;
  logic          run;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_re;
  logic [DW-1:0] wr_im;

  logic          frame_valid;
  logic          frame_ack;
  logic          overrun;
  logic          short_frame;

  modport master (
    output sample, imag, run, addr, din, frame_ack,
    input  wr_en, wr_addr, wr_re, wr_im, frame_valid, overrun, short_frame
  );

  modport slave (
    input  sample, imag, run, addr, din, frame_ack,
    output wr_en, wr_addr, wr_re, wr_im, frame_valid, overrun, short_frame
  );
endinterface

// File: rtl/fft_input_loader.sv
// Captures an N-point complex frame from the sampler into FFT working RAM and hands it off via valid/ack.
// Optional macro LOADER_BITREV_EN: write pairs at the bit-reversed address (decimation-in-time order).
module fft_input_loader #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_input_loader_if.slave  bus
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] re_hold_q, re_hold_d;
  logic [CW-1:0] pair_cnt_q, pair_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_re_q, wr_re_d;
  logic [DW-1:0] wr_im_q, wr_im_d;
  logic          frame_valid_q, frame_valid_d;
  logic          overrun_q, overrun_d;
  logic          short_frame_q, short_frame_d;

  logic          start_c;
  logic          capture_c;
  logic          pair_done_c;

  // RAM address mapping for a point index
  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
    logic [AW-1:0] m;
`ifdef LOADER_BITREV_EN
    for (int unsigned i = 0; i < AW; i++) begin
      m[i] = a[AW-1-i];
    end
`else
    m = a;
`endif
    return m;
  endfunction

  // The strobe that opens a frame is itself a capture
  assign start_c     = (state_q == S_IDLE) && bus.run && bus.sample;
  assign capture_c   = bus.sample && ((state_q == S_FILL) || start_c);
  assign pair_done_c = capture_c && bus.imag && (pair_cnt_q == CW'(N - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      re_hold_q     <= '0;
      pair_cnt_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_re_q       <= '0;
      wr_im_q       <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      re_hold_q     <= re_hold_d;
      pair_cnt_q    <= pair_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_re_q       <= wr_re_d;
      wr_im_q       <= wr_im_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      short_frame_q <= short_frame_d;
    end
  end

  // Next state: a completing pair wins over run falling in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_c) state_d = S_FILL;
      S_FILL: begin
        if (pair_done_c)   state_d = S_FULL;
        else if (!bus.run) state_d = S_IDLE;
      end
      S_FULL: if (bus.frame_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and capture datapath
  always_comb begin
    re_hold_d     = re_hold_q;
    pair_cnt_d    = pair_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_re_d       = wr_re_q;
    wr_im_d       = wr_im_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    short_frame_d = short_frame_q;

    if (start_c) begin
      overrun_d     = 1'b0;
      short_frame_d = 1'b0;
      pair_cnt_d    = '0;
    end

    if (capture_c) begin
      if (!bus.imag) begin
        re_hold_d = bus.din;
      end else begin
        wr_en_d    = 1'b1;
        wr_addr_d  = map_addr(bus.addr);
        wr_re_d    = re_hold_q;
        wr_im_d    = bus.din;
        pair_cnt_d = pair_cnt_q + CW'(1);
      end
    end

    case (state_q)
      S_FILL: begin
        if (pair_done_c) begin
          frame_valid_d = 1'b1;
          pair_cnt_d    = '0;
        end else if (!bus.run) begin
          short_frame_d = 1'b1;
          pair_cnt_d    = '0;
        end
      end
      S_FULL: begin
        if (bus.sample)    overrun_d     = 1'b1;
        if (bus.frame_ack) frame_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_re       = wr_re_q;
  assign bus.wr_im       = wr_im_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.short_frame = short_frame_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader against a frame-level behavioural model.
// Honours LOADER_BITREV_EN for the expected write address.
module tb_fft_input_loader;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned VW = 1 + AW + 2 * DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_input_loader_if #(.N(N), .DW(DW)) bus ();
  fft_input_loader #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Frame-level model: which phase we are in, how many pairs have landed, last real part
  bit            m_filling, m_full;
  int            m_pairs;
  logic [DW-1:0] m_re;
  logic          e_wr_en, e_fv, e_ovr, e_short;
  logic [AW-1:0] e_wr_addr;
  logic [DW-1:0] e_wr_re, e_wr_im;

  function automatic logic [AW-1:0] exp_map(input logic [AW-1:0] a);
`ifdef LOADER_BITREV_EN
    int x = int'(a);
    int r = 0;
    for (int i = 0; i < int'(AW); i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return AW'(r);
`else
    return a;
`endif
  endfunction

  function automatic void model_reset();
    m_filling = 0; m_full = 0; m_pairs = 0; m_re = '0;
    e_wr_en = 0; e_wr_addr = '0; e_wr_re = '0; e_wr_im = '0;
    e_fv = 0; e_ovr = 0; e_short = 0;
  endfunction

  function automatic void model_step(input logic s, input logic im, input logic r,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic ack);
    e_wr_en = 0;
    if (m_full) begin
      if (s) e_ovr = 1;
      if (ack) begin m_full = 0; e_fv = 0; end
      return;
    end
    if (!m_filling && s && r) begin
      m_filling = 1; e_ovr = 0; e_short = 0; m_pairs = 0;
    end
    if (m_filling) begin
      if (s && !im) m_re = d;
      if (s && im) begin
        e_wr_en = 1; e_wr_addr = exp_map(a); e_wr_re = m_re; e_wr_im = d;
        m_pairs++;
      end
      if (m_pairs == int'(N)) begin
        m_filling = 0; m_full = 1; e_fv = 1; m_pairs = 0;
      end else if (!r) begin
        m_filling = 0; e_short = 1; m_pairs = 0;
      end
    end
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.wr_en, bus.wr_addr, bus.wr_re, bus.wr_im, bus.frame_valid, bus.overrun, bus.short_frame};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_wr_en, e_wr_addr, e_wr_re, e_wr_im, e_fv, e_ovr, e_short};
  endfunction

  // One clock: drive inputs, advance model, sample 1ns after the edge
  task automatic cyc(input logic s, input logic im, input logic r,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
    bus.sample = s; bus.imag = im; bus.run = r; bus.addr = a; bus.din = d; bus.frame_ack = ack;
    model_step(s, im, r, a, d, ack);
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.sample = 0; bus.imag = 0; bus.run = 0; bus.addr = '0; bus.din = '0; bus.frame_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    cyc(1'b1, 1'b1, 1'b0, AW'(3), DW'(16'h1234), 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle_strobe_no_run: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_frame();
    logic [AW-1:0] got_addr [N];
    apply_reset();
    for (int k = 0; k < int'(N); k++) begin
      cyc(1'b0 | 1'b1, 1'b0, 1'b1, AW'(k), DW'(k), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.wr_en !== 1'b0) begin
        errors++; $display("FAIL frame_real k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      cyc(1'b1, 1'b1, 1'b1, AW'(k), DW'(-k), 1'b0);
      got_addr[k] = bus.wr_addr;
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_re !== DW'(k) || bus.wr_im !== DW'(-k) ||
          bus.wr_addr !== exp_map(AW'(k)) || bus.frame_valid !== (k == int'(N) - 1)) begin
        errors++;
        $display("FAIL frame_write k=%0d: got en=%b addr=%0d re=%h im=%h fv=%b want en=1 addr=%0d re=%h im=%h fv=%b",
                 k, bus.wr_en, bus.wr_addr, bus.wr_re, bus.wr_im, bus.frame_valid,
                 exp_map(AW'(k)), DW'(k), DW'(-k), (k == int'(N) - 1));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL frame_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
`ifdef LOADER_BITREV_EN
    if (got_addr[1] !== AW'(8) || got_addr[3] !== AW'(12) || got_addr[15] !== AW'(15)) begin
      errors++; $display("FAIL addr_map: got %0d %0d %0d want 8 12 15", got_addr[1], got_addr[3], got_addr[15]);
    end
`else
    if (got_addr[1] !== AW'(1) || got_addr[3] !== AW'(3) || got_addr[15] !== AW'(15)) begin
      errors++; $display("FAIL addr_map: got %0d %0d %0d want 1 3 15", got_addr[1], got_addr[3], got_addr[15]);
    end
`endif
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL frame_ack: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rehold_overwrite();
    apply_reset();
    cyc(1'b1, 1'b0, 1'b1, AW'(0), DW'(5), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, AW'(0), DW'(7), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL rehold_no_early_write: got wr_en=%b want 0", bus.wr_en);
    end
    cyc(1'b1, 1'b1, 1'b1, AW'(0), DW'(2), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_re !== DW'(7) || bus.wr_im !== DW'(2) || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL rehold_overwrite: got en=%b re=%h im=%h want en=1 re=0007 im=0002",
                         bus.wr_en, bus.wr_re, bus.wr_im);
    end
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL wr_en_one_cycle: got %b want 0", bus.wr_en);
    end
  endtask

  task automatic fill_random(input int pairs, input string tag);
    for (int k = 0; k < pairs; k++) begin
      cyc(1'b1, 1'b0, 1'b1, AW'($urandom), DW'($urandom), 1'b0);
      cyc(1'b1, 1'b1, 1'b1, AW'($urandom), DW'($urandom), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL %s pair=%0d: got %h want %h", tag, k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    fill_random(int'(N), "overrun_fill");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'($urandom), 1'b1, AW'($urandom), DW'($urandom), 1'b0);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.overrun !== 1'b1 || bus.frame_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL overrun_drop i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_ack: got fv=%b ovr=%b want fv=0 ovr=1", bus.frame_valid, bus.overrun);
    end
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL ack_in_idle_ignored: got %h want %h", obs_vec(), exp_vec());
    end
    cyc(1'b1, 1'b0, 1'b1, AW'(0), DW'(1), 1'b0);
    checks++;
    if (bus.overrun !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL overrun_clear_on_fill: got ovr=%b want 0", bus.overrun);
    end
  endtask

  task automatic test_short_frame();
    apply_reset();
    fill_random(5, "short_fill");
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.short_frame !== 1'b1 || bus.frame_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL short_frame_set: got sf=%b fv=%b want sf=1 fv=0", bus.short_frame, bus.frame_valid);
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, AW'(2), DW'(9), 1'b0);
    checks++;
    if (bus.short_frame !== 1'b0) begin
      errors++; $display("FAIL short_frame_clear_on_fill: got %b want 0", bus.short_frame);
    end
    cyc(1'b1, 1'b1, 1'b1, AW'(2), DW'(3), 1'b0);
    fill_random(int'(N) - 1, "short_refill");
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.short_frame !== 1'b0) begin
      errors++; $display("FAIL refill_valid: got fv=%b sf=%b want fv=1 sf=0", bus.frame_valid, bus.short_frame);
    end
  endtask

  task automatic test_run_fall();
    apply_reset();
    fill_random(int'(N) - 1, "runfall_fill");
    cyc(1'b1, 1'b0, 1'b1, AW'(15), DW'(11), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, AW'(15), DW'(12), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.frame_valid !== 1'b1 || bus.short_frame !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL run_fall_completing: got %h want %h", obs_vec(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    fill_random(3, "runfall_partial");
    cyc(1'b1, 1'b0, 1'b1, AW'(4), DW'(21), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, AW'(4), DW'(22), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_re !== DW'(21) || bus.short_frame !== 1'b1 || bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL run_fall_partial: got en=%b re=%h sf=%b fv=%b want en=1 re=0015 sf=1 fv=0",
                         bus.wr_en, bus.wr_re, bus.short_frame, bus.frame_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cyc(1'b1, 1'b0, 1'b1, AW'(6), DW'(40), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, AW'(6), DW'(41), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b1) begin
      errors++; $display("FAIL async_pre_write: got wr_en=%b want 1", bus.wr_en);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL async_reset_immediate: got %h want 0", obs_vec());
    end
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, AW'(7), DW'(50), 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL async_reset_mid_pair: got %h want 0", obs_vec());
    end
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, AW'(7), DW'(51), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL async_no_write_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0),
          AW'($urandom), DW'($urandom), ($urandom_range(0, 4) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cycle=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.sample = 0; bus.imag = 0; bus.run = 0; bus.addr = '0; bus.din = '0; bus.frame_ack = 0;
    test_reset();
    test_full_frame();
    test_rehold_overwrite();
    test_overrun();
    test_short_frame();
    test_run_fall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
